// File: rtl/avalon_vga_pixel_master.sv
// Avalon-MM master that polls DrawX/DrawY from the VGA register slave, fetches a colour
// for that coordinate over a request/ack port and writes it back as Red, Green, Blue.
module avalon_vga_pixel_master #(
   parameter int TIMEOUT  = 64,
   parameter bit SKIP_DUP = 1'b1
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        ENABLE,
   output logic        AVM_CS,
   output logic        AVM_READ,
   output logic        AVM_WRITE,
   output logic [2:0]  AVM_ADDR,
   output logic [3:0]  AVM_BYTE_EN,
   output logic [31:0] AVM_WRITEDATA,
   input  logic [31:0] AVM_READDATA,
   input  logic        AVM_WAITREQUEST,
   input  logic        AVM_READDATAVALID,
   output logic        PIX_REQ,
   output logic [9:0]  PIX_X,
   output logic [9:0]  PIX_Y,
   input  logic        PIX_ACK,
   input  logic [23:0] PIX_RGB,
   output logic        BUSY,
   output logic [7:0]  ERR_COUNT
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [3:0] {
      IDLE, RD_X, WT_X, RD_Y, WT_Y, CMP, FETCH, WR_R, WR_G, WR_B
   } state_t;

   typedef struct packed {
      logic        cs;
      logic        read;
      logic        write;
      logic        req;
      logic [2:0]  addr;
      logic [31:0] wdata;
   } cmd_t;

   // Command presented on entry to a state; all-zero for states that issue nothing.
   function automatic cmd_t cmd_of(state_t s, logic [23:0] rgb);
      cmd_t c;
      c = '0;
      case (s)
         RD_X:    begin c.cs = 1'b1; c.read = 1'b1;  c.addr = 3'd3; end
         RD_Y:    begin c.cs = 1'b1; c.read = 1'b1;  c.addr = 3'd4; end
         FETCH:   c.req = 1'b1;
         WR_R:    begin c.cs = 1'b1; c.write = 1'b1; c.addr = 3'd0; c.wdata = {24'h0, rgb[7:0]};   end
         WR_G:    begin c.cs = 1'b1; c.write = 1'b1; c.addr = 3'd1; c.wdata = {24'h0, rgb[15:8]};  end
         WR_B:    begin c.cs = 1'b1; c.write = 1'b1; c.addr = 3'd2; c.wdata = {24'h0, rgb[23:16]}; end
         default: c = '0;
      endcase
      return c;
   endfunction

   state_t        state_q, state_d;
   cmd_t          cmd_q, cmd_d;
   logic          done_q, done_d;
   logic          got_q, got_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [9:0]    x_q, x_d, y_q, y_d;
   logic [9:0]    last_x_q, last_x_d, last_y_q, last_y_d;
   logic          last_vld_q, last_vld_d;
   logic [23:0]   rgb_q, rgb_d;
   logic [7:0]    err_q, err_d;
   logic          accept;
   state_t        restart;
   logic          unused_rd_hi;

   assign unused_rd_hi = ^AVM_READDATA[31:10];
   assign accept  = (cmd_q.cs && !AVM_WAITREQUEST) || (cmd_q.req && PIX_ACK);
   assign restart = ENABLE ? RD_X : IDLE;

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the case infers a latch.
      state_d    = state_q;
      done_d     = done_q;
      got_d      = got_q;
      timer_d    = timer_q;
      x_d        = x_q;
      y_d        = y_q;
      last_x_d   = last_x_q;
      last_y_d   = last_y_q;
      last_vld_d = last_vld_q;
      rgb_d      = rgb_q;
      err_d      = err_q;
      case (state_q)
         IDLE: if (ENABLE) state_d = RD_X;
         RD_X, RD_Y: if (accept) begin
            timer_d = '0;
            got_d   = AVM_READDATAVALID;
            if (AVM_READDATAVALID && state_q == RD_X) x_d = AVM_READDATA[9:0];
            if (AVM_READDATAVALID && state_q == RD_Y) y_d = AVM_READDATA[9:0];
            state_d = (state_q == RD_X) ? WT_X : WT_Y;
         end
         WT_X, WT_Y: begin
            if (got_q || AVM_READDATAVALID) begin
               got_d = 1'b0;
               if (!got_q && state_q == WT_X) x_d = AVM_READDATA[9:0];
               if (!got_q && state_q == WT_Y) y_d = AVM_READDATA[9:0];
               state_d = (state_q == WT_X) ? RD_Y : CMP;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               timer_d = '0;
               if (err_q != 8'hFF) err_d = err_q + 8'd1;
               state_d = restart;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         CMP: begin
            if (SKIP_DUP && last_vld_q && x_q == last_x_q && y_q == last_y_q) state_d = restart;
            else state_d = FETCH;
         end
         FETCH, WR_R, WR_G, WR_B: begin
            // done_q marks the idle cycle after acceptance, before the next command goes out.
            if (done_q) begin
               done_d = 1'b0;
               case (state_q)
                  FETCH:   state_d = WR_R;
                  WR_R:    state_d = WR_G;
                  WR_G:    state_d = WR_B;
                  default: state_d = restart;
               endcase
            end else if (accept) begin
               done_d = 1'b1;
               if (state_q == FETCH) rgb_d = PIX_RGB;
               if (state_q == WR_B) begin
                  last_x_d   = x_q;
                  last_y_d   = y_q;
                  last_vld_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      cmd_d = cmd_q;
      if (state_d != state_q) cmd_d = cmd_of(state_d, rgb_d);
      else if (accept)        cmd_d = '0;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= IDLE;
         cmd_q      <= '0;
         done_q     <= 1'b0;
         got_q      <= 1'b0;
         timer_q    <= '0;
         x_q        <= '0;
         y_q        <= '0;
         last_x_q   <= '0;
         last_y_q   <= '0;
         last_vld_q <= 1'b0;
         rgb_q      <= '0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         done_q     <= done_d;
         got_q      <= got_d;
         timer_q    <= timer_d;
         x_q        <= x_d;
         y_q        <= y_d;
         last_x_q   <= last_x_d;
         last_y_q   <= last_y_d;
         last_vld_q <= last_vld_d;
         rgb_q      <= rgb_d;
         err_q      <= err_d;
      end
   end

   assign AVM_CS        = cmd_q.cs;
   assign AVM_READ      = cmd_q.read;
   assign AVM_WRITE     = cmd_q.write;
   assign AVM_ADDR      = cmd_q.addr;
   assign AVM_BYTE_EN   = {4{cmd_q.cs}};
   assign AVM_WRITEDATA = cmd_q.wdata;
   assign PIX_REQ       = cmd_q.req;
   assign PIX_X         = x_q;
   assign PIX_Y         = y_q;
   assign BUSY          = (state_q != IDLE);
   assign ERR_COUNT     = err_q;

endmodule

// File: doc/avalon_vga_pixel_master.md
Name: avalon_vga_pixel_master

Overview:
- Avalon-MM master that drives the VGA pixel-register slave from the initiator side.
- Per iteration:
  - reads DrawX (word 3) and DrawY (word 4);
  - fetches a 24-bit colour for that coordinate from a pixel-source handshake port;
  - writes Red, Green and Blue (words 0, 1, 2).
- Sits between the colour/sprite logic and the VGA register slave on the same fabric.

Parameters:
- TIMEOUT, 64: maximum cycles to wait for AVM_READDATAVALID after a read is accepted.
- SKIP_DUP, 1: when 1, a coordinate pair equal to the previously serviced pair skips fetch and write.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- ENABLE  in  1  run when high.
- AVM_CS  out  1  chip select, high with any command.
- AVM_READ  out  1  read command.
- AVM_WRITE  out  1  write command.
- AVM_ADDR  out  3  word address.
- AVM_BYTE_EN  out  4  always 4'hF while a command is asserted, else 0.
- AVM_WRITEDATA  out  32  write data.
- AVM_READDATA  in  32  read data.
- AVM_WAITREQUEST  in  1  slave stall.
- AVM_READDATAVALID  in  1  read data valid.
- PIX_REQ  out  1  colour request.
- PIX_X  out  10  requested X.
- PIX_Y  out  10  requested Y.
- PIX_ACK  in  1  colour valid.
- PIX_RGB  in  24  {B[23:16], G[15:8], R[7:0]}.
- BUSY  out  1  state != IDLE.
- ERR_COUNT  out  8  saturating read-timeout count.

Behaviour:
- Reset (asynchronous, RESET_N low):
  - all outputs 0;
  - state IDLE;
  - last-pair register invalid;
  - timeout counter 0.
- States: IDLE, RD_X, WT_X, RD_Y, WT_Y, CMP, FETCH, WR_R, WR_G, WR_B.
- IDLE -> RD_X when ENABLE=1.
- Command rule (RD_*, WR_*):
  - CS, READ/WRITE, ADDR and WRITEDATA are registered outputs, asserted on state entry.
  - They are held unchanged while AVM_WAITREQUEST=1.
  - The command is accepted in the first cycle it is asserted with WAITREQUEST=0.
  - Next cycle: command outputs drop and the state advances.
- RD_X uses ADDR=3, RD_Y uses ADDR=4.
- On acceptance, go to WT_X / WT_Y with the timeout counter cleared.
- WT_*:
  - On AVM_READDATAVALID=1, capture READDATA[9:0] into X/Y and advance (WT_X->RD_Y, WT_Y->CMP).
  - READDATAVALID in the acceptance cycle itself is also honoured, giving zero-latency slaves.
  - Counter reaching TIMEOUT without valid: ERR_COUNT += 1 (saturates at 255), return to RD_X, discard the partial pair.
  - READDATAVALID in any other state is ignored.
- CMP, one cycle:
  - If SKIP_DUP=1, the last pair is valid and (X,Y) equals the last pair -> RD_X.
  - Otherwise -> FETCH.
- FETCH:
  - PIX_REQ=1 with PIX_X/PIX_Y = captured X/Y, held until PIX_ACK=1.
  - On PIX_ACK, latch PIX_RGB; PIX_REQ drops next cycle -> WR_R.
  - PIX_ACK while PIX_REQ=0 is ignored.
- Write data, upper bits zero:
  - WR_R: ADDR=0, WRITEDATA={24'b0,R}.
  - WR_G: ADDR=1, WRITEDATA={24'b0,G}.
  - WR_B: ADDR=2, WRITEDATA={24'b0,B}.
- Writes are strictly ordered R, G, B. After WR_B is accepted, record (X,Y) as the last pair (valid) -> RD_X.
- Never more than one outstanding command. READ and WRITE are never high together.
- ENABLE low:
  - An asserted command or pending read/fetch always completes; the block never drops a command under waitrequest.
  - At the next transition that would re-enter RD_X, go to IDLE instead.
  - The last pair stays valid.
- Throughput with no stalls and zero-latency read data: 2 cycles per command/FETCH.

Test Plan:
- No-stall slave, reads X=5 then Y=7, PIX_ACK same cycle RGB=24'h332211 -> PIX_X=5, PIX_Y=7; writes ADDR0=0x11, ADDR1=0x22, ADDR2=0x33 in order; then RD_X reissued.
- WAITREQUEST high 3 cycles on WR_G -> ADDR=1, WRITEDATA=0x22, WRITE held stable all 4 cycles; exactly one write accepted; WR_B follows.
- Slave returns X=5, Y=7 twice with SKIP_DUP=1 -> second iteration issues no PIX_REQ and no writes. Then Y=8 -> full fetch and write.
- READDATAVALID never asserted after RD_Y accepted, TIMEOUT=64 -> after 64 cycles ERR_COUNT=1, next command is RD_X (ADDR=3). 300 consecutive timeouts -> ERR_COUNT=255.
- ENABLE dropped during FETCH with PIX_ACK delayed 5 cycles -> PIX_REQ held until ack; WR_R/G/B complete; then IDLE, BUSY=0.
- RESET_N asserted mid-WR_G with WAITREQUEST=1 -> CS, WRITE, BYTE_EN and PIX_REQ go to 0 immediately without a clock edge. After release with ENABLE=1 -> first command RD_X, and the previous pair does not cause a skip.
